// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants and state encoding for the FIR sample
//                buffer and its RAM banks.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int SAMPLE_W  = 18;
    localparam int NUM_LANES = 8;
    localparam int ROW_AW    = 11;
    localparam int BUF_AW    = 14;
    localparam int FILL_W    = BUF_AW + 1;
    localparam int DATA_W    = SAMPLE_W * NUM_LANES;
    localparam int BUF_DEPTH = 1 << BUF_AW;

    // Control state encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_sample_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_buffer_if
//  Description : Sample-in handshake plus FIR engine read/control signals.
//                The master side is the source/engine, the slave side is the
//                sample buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_sample_buffer_if;
    import fir_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_in_valid;
    logic                sample_in_ready;
    logic [ROW_AW-1:0]   addr_data;
    logic [DATA_W-1:0]   datain;
    logic                datain_ready;
    logic                dataout_ready;

    modport master (
        output sample_in, sample_in_valid, addr_data, dataout_ready,
        input  sample_in_ready, datain, datain_ready
    );

    modport slave (
        input  sample_in, sample_in_valid, addr_data, dataout_ready,
        output sample_in_ready, datain, datain_ready
    );

endinterface
`default_nettype wire

// File: rtl/fir_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fir_bank_ram
//  Description : One lane of the sample store: 2048 x 18 simple dual-port
//                RAM, one write port and one registered read port. Contents
//                are never cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_bank_ram
    import fir_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                i_we,
    input  wire logic [ROW_AW-1:0]   i_waddr,
    input  wire logic [SAMPLE_W-1:0] i_wdata,
    input  wire logic [ROW_AW-1:0]   i_raddr,
    output logic      [SAMPLE_W-1:0] o_rdata
);

    logic [SAMPLE_W-1:0] r_mem [0:(1<<ROW_AW)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/fir_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_buffer
//  Description : 16384-sample circular history for a FIR engine. Each
//                accepted sample triggers one datain_ready pulse; the engine
//                then reads eight past samples per row and signals
//                completion with dataout_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_buffer
    import fir_pkg::*;
(
    input  wire logic          clock,
    input  wire logic          reset,
    fir_sample_buffer_if.slave bus
);

    state_t               r_state;
    logic [BUF_AW-1:0]    r_wp;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_in_ready;
    logic                 r_datain_ready;
    logic [DATA_W-1:0]    r_datain;
    logic [2:0]           r_shift_q;
    logic [NUM_LANES-1:0] r_zero_q;

    logic                 w_wr_en;
    logic [BUF_AW-1:0]    w_wp_next;
    logic [ROW_AW-1:0]    w_row_base;
    logic [2:0]           w_shift;
    logic [2:0]           w_lane;
    logic [ROW_AW-1:0]    w_rd_row [NUM_LANES];
    logic [SAMPLE_W-1:0]  w_rdata  [NUM_LANES];
    logic [NUM_LANES-1:0] w_zero;
    logic [DATA_W-1:0]    w_datain_next;

    // Writes happen only on acceptance in IDLE, which keeps reads hazard-free
    assign w_wr_en    = (r_state == ST_IDLE) && bus.sample_in_valid;
    assign w_wp_next  = r_wp + BUF_AW'(1);

    assign w_row_base = r_wp[BUF_AW-1:3] - bus.addr_data;
    assign w_shift    = r_wp[2:0];

    assign bus.sample_in_ready = r_in_ready;
    assign bus.datain_ready    = r_datain_ready;
    assign bus.datain          = r_datain;

    // Control FSM: accept one sample, pulse the engine, wait for completion
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_wp           <= '1;
            r_fill         <= '0;
            r_in_ready     <= 1'b1;
            r_datain_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.sample_in_valid) begin
                        r_wp           <= w_wp_next;
                        if (r_fill != FILL_W'(BUF_DEPTH)) begin
                            r_fill <= r_fill + FILL_W'(1);
                        end
                        r_in_ready     <= 1'b0;
                        r_datain_ready <= 1'b1;
                        r_state        <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    r_datain_ready <= 1'b0;
                    r_state        <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.dataout_ready) begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready     <= 1'b1;
                    r_datain_ready <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-lane row: lanes at or below the rotation point sit in the base row,
    // the rest wrap into the previous row. Slots past the fill level are masked.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_rd_row[l] = (3'(l) <= w_shift) ? w_row_base : (w_row_base - ROW_AW'(1));
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            w_zero[k] = ({1'b0, bus.addr_data, 3'(k)} >= r_fill);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            fir_bank_ram u_ram (
                .clk     (clock),
                .i_we    (w_wr_en && (w_wp_next[2:0] == 3'(g))),
                .i_waddr (w_wp_next[BUF_AW-1:3]),
                .i_wdata (bus.sample_in),
                .i_raddr (w_rd_row[g]),
                .o_rdata (w_rdata[g])
            );
        end
    endgenerate

    // Rotate lanes into slot order (slot k takes lane wp-k) and apply the mask
    always_comb begin
        w_datain_next = '0;
        w_lane        = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_lane = r_shift_q - 3'(k);
            if (!r_zero_q[k]) begin
                w_datain_next[DATA_W-1-k*SAMPLE_W -: SAMPLE_W] = w_rdata[w_lane];
            end
        end
    end

    // Rotation and mask travel alongside the RAM read, then datain is registered.
    // The mask resets to all-zeroed so stale RAM never leaks right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift_q <= '0;
            r_zero_q  <= '1;
            r_datain  <= '0;
        end else begin
            r_shift_q <= w_shift;
            r_zero_q  <= w_zero;
            r_datain  <= w_datain_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_sample_buffer
//  Description : Self-checking bench for fir_sample_buffer with a reference
//                history model and a read scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sample_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fir_sample_buffer_if bus ();

    fir_sample_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           addr;
        logic [143:0] exp;
    } rd_item_t;

    rd_item_t    sb_q[$];
    logic        rd_req = 1'b0;
    logic        rd_v1  = 1'b0;
    logic        rd_v2  = 1'b0;

    logic [17:0] m_mem [16384];
    int          m_wp;
    int          m_fill;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] expect_row(input int a);
        logic [143:0] r;
        int n;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            n = 8 * a + k;
            if (n < m_fill) r[143-18*k -: 18] = m_mem[(m_wp - n) & 16383];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_wp   = 16383;
        m_fill = 0;
    endtask

    task automatic model_write(input logic [17:0] v);
        m_wp = (m_wp + 1) & 16383;
        m_mem[m_wp] = v;
        if (m_fill < 16384) m_fill++;
    endtask

    // Read pipeline tracker: datain is due two edges after the request
    always @(posedge clock) begin
        rd_v1 <= rd_req;
        rd_v2 <= rd_v1;
    end

    always @(negedge clock) begin
        rd_item_t it;
        if (rd_v2) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 144'd1, 144'd0);
            end else begin
                it = sb_q.pop_front();
                check($sformatf("datain_a%0d", it.addr), bus.datain, it.exp);
            end
        end
    end

    task automatic read_row(input int a);
        rd_item_t it;
        it.addr = a;
        it.exp  = expect_row(a);
        sb_q.push_back(it);
        bus.addr_data = 11'(a);
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.sample_in_valid = 1'b0;
        bus.dataout_ready   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("rst_ready", bus.sample_in_ready, 1'b1);
        check("rst_pulse", bus.datain_ready, 1'b0);
        check("rst_datain", bus.datain, 144'd0);
    endtask

    // Present a sample, wait (bounded) for acceptance, optionally complete it
    task automatic accept_sample(input logic [17:0] v, input bit chk, input bit fin);
        int waited;
        waited = 0;
        bus.sample_in = v;
        bus.sample_in_valid = 1'b1;
        while (!bus.sample_in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.sample_in_ready) begin
            check("accept_timeout", 144'd0, 144'd1);
            bus.sample_in_valid = 1'b0;
            return;
        end
        @(negedge clock);
        model_write(v);
        bus.sample_in_valid = 1'b0;
        if (chk) begin
            check("acc_ready_low", bus.sample_in_ready, 1'b0);
            check("acc_pulse", bus.datain_ready, 1'b1);
        end
        if (fin) begin
            @(negedge clock);
            if (chk) check("pulse_single", bus.datain_ready, 1'b0);
            bus.dataout_ready = 1'b1;
            @(negedge clock);
            bus.dataout_ready = 1'b0;
        end
    endtask

    initial begin
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;
        bus.addr_data       = '0;
        bus.dataout_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        do_reset();

        // Single sample
        accept_sample(18'h00001, 1'b1, 1'b1);
        read_row(0);
        read_row(1);
        drain();

        // Nine samples, rotated read across a row boundary
        do_reset();
        for (int i = 1; i <= 9; i++) accept_sample(18'(i), 1'b1, 1'b1);
        read_row(0);
        read_row(1);
        read_row(2);
        drain();

        // dataout_ready in IDLE is ignored
        bus.dataout_ready = 1'b1;
        @(negedge clock);
        bus.dataout_ready = 1'b0;
        check("idle_dout_ready", bus.sample_in_ready, 1'b1);
        check("idle_dout_pulse", bus.datain_ready, 1'b0);
        accept_sample(18'h2AAAA, 1'b1, 1'b1);
        read_row(0);
        read_row(1);
        drain();

        // Valid held high; completion every 20 cycles
        begin
            logic [17:0] v;
            v = 18'h3FFF0;
            for (int i = 0; i < 100; i++) begin
                check("hold_ready", bus.sample_in_ready, (i % 20) == 0);
                check("hold_pulse", bus.datain_ready, (i % 20) == 1);
                if (i % 20 == 0) model_write(v);
                if (i % 20 == 1) v = v + 18'd1;
                bus.sample_in       = v;
                bus.sample_in_valid = 1'b1;
                bus.dataout_ready   = (i % 20) == 19;
                @(negedge clock);
            end
            bus.sample_in_valid = 1'b0;
            bus.dataout_ready   = 1'b0;
            @(negedge clock);
            check("hold_end_ready", bus.sample_in_ready, 1'b1);
            read_row(0);
            read_row(1);
            read_row(2);
            drain();
        end

        // Reset while BUSY abandons the computation and hides history
        do_reset();
        for (int i = 0; i < 99; i++) accept_sample(18'(i + 500), 1'b0, 1'b1);
        accept_sample(18'd599, 1'b1, 1'b0);
        @(negedge clock);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("post_rst_pulse", bus.datain_ready, 1'b0);
            @(negedge clock);
        end
        for (int a = 0; a < 2048; a++) read_row(a);
        drain();

        // Full wrap: 16387 samples, value = index
        do_reset();
        for (int i = 0; i < 16387; i++) accept_sample(18'(i), 1'b0, 1'b1);
        check("wrap_model_head", 144'(m_mem[2]), 144'd16386);
        read_row(0);
        read_row(2047);
        for (int i = 0; i < 16; i++) read_row(int'($urandom_range(0, 2047)));
        drain();

        check("sb_empty", 144'(sb_q.size()), 144'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
